// File: rtl/visor_dbg_pkg.sv
// Purpose: shared types and constants for the visor debug unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package visor_dbg_pkg;

    // Debug state machine encoding
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } state_e;

    // Supervisor register selects
    localparam logic [2:0] CFG_SEL_CMD      = 3'd0;
    localparam logic [2:0] CFG_SEL_BP_INDEX = 3'd1;
    localparam logic [2:0] CFG_SEL_BP_ADDR  = 3'd2;
    localparam logic [2:0] CFG_SEL_BP_MASK  = 3'd3;
    localparam logic [2:0] CFG_SEL_BP_CTRL  = 3'd4;
    localparam logic [2:0] CFG_SEL_TRACE    = 3'd5;

    // Bit positions inside a CMD write
    localparam int CMD_RESUME = 0;
    localparam int CMD_STEP   = 1;
    localparam int CMD_HALT   = 2;
    localparam int CMD_CLEAR  = 3;

endpackage

// File: rtl/visor_trace_buf.sv
// Purpose: circular execution-trace buffer; overwrites the oldest entry when full.
// Latency: push/pop/clear take effect at the next clock edge; oldest_dat and count are registered-state views.
// Backpressure: none - push never stalls, pop on empty is ignored, clear drops a same-cycle push.
//
// Ports: clk/rst_n (async active-low), push/push_dat, pop, clear,
//        count (0..TRACE_DEPTH), oldest_dat (0 when empty).
module visor_trace_buf
    import visor_dbg_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int TRACE_DEPTH = 8,
    localparam int PTR_W      = $clog2(TRACE_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_dat,
    input  logic              pop,
    input  logic              clear,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] oldest_dat
);

    logic [ADDR_W-1:0] mem_q [TRACE_DEPTH];
    logic [ADDR_W-1:0] mem_d [TRACE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic full;
    logic empty;
    logic push_eff;
    logic pop_eff;

    assign full     = (count_q == CNT_W'(TRACE_DEPTH));
    assign empty    = (count_q == '0);
    assign push_eff = push && !clear;
    assign pop_eff  = pop && !empty && !clear;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            // A push into a full buffer discards the oldest entry, so the read
            // pointer moves once whether that was due to a pop, the overwrite, or both.
            if (pop_eff || (push_eff && full)) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_eff && !pop_eff && !full) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_eff && !push_eff) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign oldest_dat = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/visor_dbg_unit.sv
// Purpose: N-breakpoint debug unit with run/halt/step control and execution trace for the Synapse316 target.
// Latency: breakpoint/halt_req halt one cycle after the triggering cycle; cfg_rdata is combinational.
// Backpressure: gates tg_code_ready low while HALTED; config bus never stalls.
//
// Ports: sysclk, sysreset_n (async active-low); rom_code_ready -> tg_code_ready gate;
//        tg_code_addr/tg_enable_exec fetch observation; cfg_sel/we/re/wdata/rdata supervisor bus;
//        halted/hit_valid/hit_index status. Assumes ADDR_W <= 16 and TRACE_DEPTH <= 128.
module visor_dbg_unit
    import visor_dbg_pkg::*;
#(
    parameter int NUM_BP      = 4,
    parameter int ADDR_W      = 16,
    parameter int CNT_W       = 8,
    parameter int TRACE_DEPTH = 8
) (
    input  logic              sysclk,
    input  logic              sysreset_n,
    input  logic              rom_code_ready,
    input  logic [ADDR_W-1:0] tg_code_addr,
    input  logic              tg_enable_exec,
    output logic              tg_code_ready,
    input  logic [2:0]        cfg_sel,
    input  logic              cfg_we,
    input  logic              cfg_re,
    input  logic [15:0]       cfg_wdata,
    output logic [15:0]       cfg_rdata,
    output logic              halted,
    output logic              hit_valid,
    output logic [3:0]        hit_index
);

    localparam int TC_W = $clog2(TRACE_DEPTH) + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic              hit_valid_q, hit_valid_d;
    logic [3:0]        hit_index_q, hit_index_d;
    logic              skip_q, skip_d;        // exempt next exec from matching after resume
    logic [3:0]        bp_index_q, bp_index_d;

    logic [NUM_BP-1:0] bp_en_q, bp_en_d;
    logic [ADDR_W-1:0] bp_addr_q   [NUM_BP];
    logic [ADDR_W-1:0] bp_addr_d   [NUM_BP];
    logic [ADDR_W-1:0] bp_mask_q   [NUM_BP];
    logic [ADDR_W-1:0] bp_mask_d   [NUM_BP];
    logic [CNT_W-1:0]  bp_reload_q [NUM_BP];
    logic [CNT_W-1:0]  bp_reload_d [NUM_BP];
    logic [CNT_W-1:0]  bp_cnt_q    [NUM_BP];
    logic [CNT_W-1:0]  bp_cnt_d    [NUM_BP];

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    logic cmd_wr, cmd_resume, cmd_step, cmd_halt, cmd_clear;

    assign cmd_wr     = cfg_we && (cfg_sel == CFG_SEL_CMD);
    assign cmd_resume = cmd_wr && cfg_wdata[CMD_RESUME];
    assign cmd_step   = cmd_wr && cfg_wdata[CMD_STEP];
    assign cmd_halt   = cmd_wr && cfg_wdata[CMD_HALT];
    assign cmd_clear  = cmd_wr && cfg_wdata[CMD_CLEAR];

    // ------------------------------------------------------------------
    // Comparators
    // ------------------------------------------------------------------
    logic              match_live;
    logic [NUM_BP-1:0] bp_match;
    logic [NUM_BP-1:0] bp_hit;
    logic              any_hit;
    logic [3:0]        hit_lowest;

    // Matches only count in RUN, and not on the exec right after a resume.
    assign match_live = (state_q == RUN) && !skip_q;

    always_comb begin
        bp_match = '0;
        bp_hit   = '0;
        for (int i = 0; i < NUM_BP; i++) begin
            bp_match[i] = bp_en_q[i] && tg_enable_exec &&
                          (((tg_code_addr ^ bp_addr_q[i]) & bp_mask_q[i]) == '0);
            bp_hit[i]   = match_live && bp_match[i] && (bp_cnt_q[i] == '0);
        end
    end

    assign any_hit = |bp_hit;

    // Scan downwards so the lowest hitting index is the one left standing.
    always_comb begin
        hit_lowest = '0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_hit[i]) begin
                hit_lowest = 4'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Run/halt/step FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        hit_valid_d = hit_valid_q;
        hit_index_d = hit_index_q;
        skip_d      = skip_q;
        case (state_q)
            RUN: begin
                if (tg_enable_exec) begin
                    skip_d = 1'b0;
                end
                if (cmd_halt) begin
                    state_d     = HALTED;
                    hit_valid_d = 1'b0;
                end else if (any_hit) begin
                    state_d     = HALTED;
                    hit_valid_d = 1'b1;
                    hit_index_d = hit_lowest;
                end
            end
            HALTED: begin
                if (cmd_step) begin
                    state_d = STEP;
                end else if (cmd_resume) begin
                    state_d = RUN;
                    skip_d  = 1'b1;
                end
            end
            STEP: begin
                if (cmd_halt || tg_enable_exec) begin
                    state_d     = HALTED;
                    hit_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Breakpoint registers and pass counters
    // ------------------------------------------------------------------
    always_comb begin
        bp_index_d  = bp_index_q;
        bp_en_d     = bp_en_q;
        bp_addr_d   = bp_addr_q;
        bp_mask_d   = bp_mask_q;
        bp_reload_d = bp_reload_q;
        bp_cnt_d    = bp_cnt_q;

        for (int i = 0; i < NUM_BP; i++) begin
            if (match_live && bp_match[i]) begin
                bp_cnt_d[i] = (bp_cnt_q[i] == '0) ? bp_reload_q[i]
                                                  : bp_cnt_q[i] - CNT_W'(1);
            end
        end

        // Supervisor writes land after the counter update so a BP_CTRL write wins.
        if (cfg_we) begin
            case (cfg_sel)
                CFG_SEL_BP_INDEX: begin
                    if (cfg_wdata < 16'(NUM_BP)) begin
                        bp_index_d = cfg_wdata[3:0];
                    end
                end
                CFG_SEL_BP_ADDR: begin
                    for (int i = 0; i < NUM_BP; i++) begin
                        if (bp_index_q == 4'(i)) bp_addr_d[i] = cfg_wdata[ADDR_W-1:0];
                    end
                end
                CFG_SEL_BP_MASK: begin
                    for (int i = 0; i < NUM_BP; i++) begin
                        if (bp_index_q == 4'(i)) bp_mask_d[i] = cfg_wdata[ADDR_W-1:0];
                    end
                end
                CFG_SEL_BP_CTRL: begin
                    for (int i = 0; i < NUM_BP; i++) begin
                        if (bp_index_q == 4'(i)) begin
                            bp_en_d[i]     = cfg_wdata[0];
                            bp_reload_d[i] = cfg_wdata[8 +: CNT_W];
                            bp_cnt_d[i]    = cfg_wdata[8 +: CNT_W];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state_q     <= RUN;
            hit_valid_q <= 1'b0;
            hit_index_q <= '0;
            skip_q      <= 1'b0;
            bp_index_q  <= '0;
            bp_en_q     <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr_q[i]   <= '0;
                bp_mask_q[i]   <= '1;
                bp_reload_q[i] <= '0;
                bp_cnt_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            hit_valid_q <= hit_valid_d;
            hit_index_q <= hit_index_d;
            skip_q      <= skip_d;
            bp_index_q  <= bp_index_d;
            bp_en_q     <= bp_en_d;
            bp_addr_q   <= bp_addr_d;
            bp_mask_q   <= bp_mask_d;
            bp_reload_q <= bp_reload_d;
            bp_cnt_q    <= bp_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Trace buffer
    // ------------------------------------------------------------------
    logic [TC_W-1:0]   trace_count;
    logic [ADDR_W-1:0] trace_oldest;
    logic              trace_pop;

    assign trace_pop = cfg_re && (cfg_sel == CFG_SEL_TRACE);

    visor_trace_buf #(
        .ADDR_W      (ADDR_W),
        .TRACE_DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk        (sysclk),
        .rst_n      (sysreset_n),
        .push       (tg_enable_exec && tg_code_ready),
        .push_dat   (tg_code_addr),
        .pop        (trace_pop),
        .clear      (cmd_clear),
        .count      (trace_count),
        .oldest_dat (trace_oldest)
    );

    // ------------------------------------------------------------------
    // Outputs and read mux
    // ------------------------------------------------------------------
    assign halted        = (state_q == HALTED);
    assign hit_valid     = hit_valid_q;
    assign hit_index     = hit_index_q;
    assign tg_code_ready = (state_q != HALTED) && rom_code_ready;

    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] cur_mask;
    logic [CNT_W-1:0]  cur_cnt;
    logic              cur_en;
    logic [7:0]        tc8;
    logic [7:0]        cnt8;

    always_comb begin
        cur_addr = '0;
        cur_mask = '0;
        cur_cnt  = '0;
        cur_en   = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bp_index_q == 4'(i)) begin
                cur_addr = bp_addr_q[i];
                cur_mask = bp_mask_q[i];
                cur_cnt  = bp_cnt_q[i];
                cur_en   = bp_en_q[i];
            end
        end
    end

    always_comb begin
        tc8              = '0;
        tc8[TC_W-1:0]    = trace_count;
        cnt8             = '0;
        cnt8[CNT_W-1:0]  = cur_cnt;
        cfg_rdata        = '0;
        case (cfg_sel)
            CFG_SEL_CMD:      cfg_rdata = {tc8, hit_valid_q, hit_index_q, 2'b00, halted};
            CFG_SEL_BP_INDEX: cfg_rdata = {12'b0, bp_index_q};
            CFG_SEL_BP_ADDR:  cfg_rdata[ADDR_W-1:0] = cur_addr;
            CFG_SEL_BP_MASK:  cfg_rdata[ADDR_W-1:0] = cur_mask;
            CFG_SEL_BP_CTRL:  cfg_rdata = {cnt8, 7'b0, cur_en};
            CFG_SEL_TRACE:    cfg_rdata[ADDR_W-1:0] = trace_oldest;
            default:          cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_visor_dbg_unit.sv
// Purpose: scoreboard bench for visor_dbg_unit; reads push expected values, a negedge monitor checks them.
// Latency: expectations are taken mid-cycle on the read strobe.
// Backpressure: n/a.
module tb_visor_dbg_unit;

    logic        sysclk;
    logic        sysreset_n;
    logic        rom_code_ready;
    logic [15:0] tg_code_addr;
    logic        tg_enable_exec;
    logic        tg_code_ready;
    logic [2:0]  cfg_sel;
    logic        cfg_we;
    logic        cfg_re;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        halted;
    logic        hit_valid;
    logic [3:0]  hit_index;

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic [15:0] rdata;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    visor_dbg_unit #(
        .NUM_BP      (4),
        .ADDR_W      (16),
        .CNT_W       (8),
        .TRACE_DEPTH (8)
    ) dut (
        .sysclk         (sysclk),
        .sysreset_n     (sysreset_n),
        .rom_code_ready (rom_code_ready),
        .tg_code_addr   (tg_code_addr),
        .tg_enable_exec (tg_enable_exec),
        .tg_code_ready  (tg_code_ready),
        .cfg_sel        (cfg_sel),
        .cfg_we         (cfg_we),
        .cfg_re         (cfg_re),
        .cfg_wdata      (cfg_wdata),
        .cfg_rdata      (cfg_rdata),
        .halted         (halted),
        .hit_valid      (hit_valid),
        .hit_index      (hit_index)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    // Monitor: every read strobe is an output event to be matched against the scoreboard.
    always @(negedge sysclk) begin
        if (cfg_re) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_read: sel=%0d rdata=%h, no expectation queued", cfg_sel, cfg_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                tests++;
                if (cfg_rdata !== mon_e.rdata || tg_code_ready !== mon_e.rdy) begin
                    fails++;
                    $display("FAIL %s: rdata=%h rdy=%b, expected rdata=%h rdy=%b",
                             mon_e.name, cfg_rdata, tg_code_ready, mon_e.rdata, mon_e.rdy);
                end
                if (mon_e.sel == 3'd0) begin
                    tests++;
                    if ({hit_valid, hit_index, halted} !== {mon_e.rdata[7], mon_e.rdata[6:3], mon_e.rdata[0]}) begin
                        fails++;
                        $display("FAIL %s_pins: hv=%b idx=%0d halted=%b, expected hv=%b idx=%0d halted=%b",
                                 mon_e.name, hit_valid, hit_index, halted,
                                 mon_e.rdata[7], mon_e.rdata[6:3], mon_e.rdata[0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic push_exp(input string nm, input logic [2:0] sel, input logic [15:0] ex, input logic exrdy);
        exp_t e;
        e.name  = nm;
        e.sel   = sel;
        e.rdata = ex;
        e.rdy   = exrdy;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [15:0] d);
        cfg_sel   = sel;
        cfg_wdata = d;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic rd(input string nm, input logic [2:0] sel, input logic [15:0] ex, input logic exrdy);
        push_exp(nm, sel, ex, exrdy);
        cfg_sel = sel;
        cfg_re  = 1'b1;
        tick();
        cfg_re  = 1'b0;
    endtask

    task automatic ex(input logic [15:0] a);
        tg_code_addr   = a;
        tg_enable_exec = 1'b1;
        tick();
        tg_enable_exec = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        sysreset_n     = 1'b0;
        rom_code_ready = 1'b1;
        tg_code_addr   = '0;
        tg_enable_exec = 1'b0;
        cfg_sel        = '0;
        cfg_we         = 1'b0;
        cfg_re         = 1'b0;
        cfg_wdata      = '0;
        tick();
        tick();
        sysreset_n = 1'b1;
        tick();

        // Reset state
        rd("reset_status", 3'd0, 16'h0000, 1'b1);
        rd("reset_mask",   3'd3, 16'hFFFF, 1'b1);
        rd("reset_ctrl",   3'd4, 16'h0000, 1'b1);
        rd("reset_trace",  3'd5, 16'h0000, 1'b1);

        // bp0 exact match at 0x0040, reload 0
        wr(3'd1, 16'd0);
        wr(3'd2, 16'h0040);
        wr(3'd3, 16'hFFFF);
        wr(3'd4, 16'h0001);
        ex(16'h0030);
        ex(16'h0040);
        rd("bp0_halt", 3'd0, 16'h0281, 1'b0);

        // Single step then resume with skip-once
        wr(3'd0, 16'h0002);
        rd("in_step", 3'd0, 16'h0280, 1'b1);
        ex(16'h0041);
        rd("step_done", 3'd0, 16'h0301, 1'b0);
        ex(16'h0099);                          // ready is low, so no trace push
        wr(3'd0, 16'h0001);
        ex(16'h0040);
        rd("skip_once", 3'd0, 16'h0400, 1'b1);
        ex(16'h0040);
        rd("rehalt", 3'd0, 16'h0581, 1'b0);

        // bp1 masked with pass count 2
        wr(3'd0, 16'h0001);
        ex(16'h0200);
        wr(3'd4, 16'h0000);
        wr(3'd1, 16'd1);
        wr(3'd2, 16'h0120);
        wr(3'd3, 16'hFFF0);
        wr(3'd4, 16'h0201);
        wr(3'd0, 16'h0008);
        ex(16'h0123);
        rd("pass1_cnt", 3'd4, 16'h0101, 1'b1);
        ex(16'h0123);
        rd("pass2_cnt", 3'd4, 16'h0001, 1'b1);
        ex(16'h0123);
        rd("pass3_halt", 3'd0, 16'h0389, 1'b0);
        rd("pass3_reload", 3'd4, 16'h0201, 1'b0);

        // bp0 and bp2 hit together -> lowest index, both reload
        wr(3'd0, 16'h0001);
        ex(16'h0000);
        wr(3'd1, 16'd0);
        wr(3'd2, 16'h0010);
        wr(3'd4, 16'h0101);
        wr(3'd1, 16'd2);
        wr(3'd2, 16'h0018);
        wr(3'd3, 16'hFFF0);
        wr(3'd4, 16'h0101);
        ex(16'h0010);
        ex(16'h0010);
        rd("dual_halt",   3'd0, 16'h0681, 1'b0);
        rd("bp2_reload",  3'd4, 16'h0101, 1'b0);
        rd("bp2_mask",    3'd3, 16'hFFF0, 1'b0);
        rd("bp2_addr",    3'd2, 16'h0018, 1'b0);
        wr(3'd1, 16'd0);
        rd("bp0_reload",  3'd4, 16'h0101, 1'b0);
        wr(3'd1, 16'd7);
        rd("bp_index_oob", 3'd1, 16'h0000, 1'b0);

        // Trace overwrite and pop order
        wr(3'd0, 16'h0009);
        for (int i = 1; i <= 10; i++) begin
            ex(16'(i));
        end
        rd("trace_full", 3'd0, 16'h0880, 1'b1);
        for (int i = 3; i <= 10; i++) begin
            rd("trace_pop", 3'd5, 16'(i), 1'b1);
        end
        rd("trace_pop_empty", 3'd5, 16'h0000, 1'b1);
        rd("trace_empty_cnt", 3'd0, 16'h0080, 1'b1);
        push_exp("trace_pushpop_empty", 3'd5, 16'h0000, 1'b1);
        cfg_sel        = 3'd5;
        cfg_re         = 1'b1;
        tg_code_addr   = 16'h0055;
        tg_enable_exec = 1'b1;
        tick();
        cfg_re         = 1'b0;
        tg_enable_exec = 1'b0;
        rd("trace_after_pushpop", 3'd5, 16'h0055, 1'b1);

        // halt_req beats a simultaneous breakpoint hit
        wr(3'd4, 16'h0001);
        tg_code_addr   = 16'h0010;
        tg_enable_exec = 1'b1;
        cfg_sel        = 3'd0;
        cfg_wdata      = 16'h0004;
        cfg_we         = 1'b1;
        tick();
        cfg_we         = 1'b0;
        cfg_wdata      = '0;
        tg_enable_exec = 1'b0;
        rd("halt_req_prio", 3'd0, 16'h0101, 1'b0);

        // Async reset in the middle of STEP
        wr(3'd0, 16'h0002);
        rd("step_before_rst", 3'd0, 16'h0100, 1'b1);
        push_exp("reset_mid_step", 3'd0, 16'h0000, 1'b1);
        cfg_sel = 3'd0;
        cfg_re  = 1'b1;
        #2 sysreset_n = 1'b0;
        tick();
        cfg_re = 1'b0;
        tick();
        sysreset_n = 1'b1;
        tick();
        rd("post_rst_status", 3'd0, 16'h0000, 1'b1);
        rd("post_rst_ctrl",   3'd4, 16'h0000, 1'b1);
        rd("post_rst_mask",   3'd3, 16'hFFFF, 1'b1);
        rd("post_rst_addr",   3'd2, 16'h0000, 1'b1);
        rd("post_rst_trace",  3'd5, 16'h0000, 1'b1);
        rd("post_rst_index",  3'd1, 16'h0000, 1'b1);
        rom_code_ready = 1'b0;
        rd("ready_passthru",  3'd0, 16'h0000, 1'b0);
        rom_code_ready = 1'b1;

        tick();
        tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
